// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer: launches one drum-grid step per sample slot and captures the centre amplitude
module drum_step_sequencer #(
    parameter int DATA_W       = 18,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 4096,
    parameter int CNT_W        = 32
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              run_en,
    input  logic              strike,
    input  logic [DATA_W-1:0] u_init_in,
    input  logic [DATA_W-1:0] rho_init_in,
    input  logic [8:0]        height_in,
    output logic              grid_reset,
    output logic              grid_start,
    output logic [DATA_W-1:0] grid_u_init,
    output logic [DATA_W-1:0] grid_rho_init,
    output logic [8:0]        grid_height,
    input  logic              grid_done,
    input  logic [DATA_W-1:0] grid_u_center,
    output logic [15:0]       sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [CNT_W-1:0]  step_count,
    output logic [15:0]       step_cycles,
    output logic              busy,
    output logic              timeout_err
);
    localparam logic [1:0]  S_STRIKE = 2'd0;
    localparam logic [1:0]  S_IDLE   = 2'd1;
    localparam logic [1:0]  S_LAUNCH = 2'd2;
    localparam logic [1:0]  S_WAIT   = 2'd3;
    localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [31:0] CC_LAST  = 32'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [15:0] rst_cnt;
    logic [31:0] cc;
    logic [31:0] cc_inc;
    logic        done_d;
    logic        rise;
    logic        expire;
    logic        capture;
    logic        abort;
    logic        go;
    logic        unused_lsbs;

    assign grid_reset  = (state == S_STRIKE);
    assign grid_start  = (state == S_LAUNCH);
    assign busy        = (state != S_IDLE);
    assign go          = run_en && (!sample_valid || sample_ready);
    assign rise        = (state == S_WAIT) && grid_done && !done_d;
    assign expire      = (state == S_WAIT) && !rise && (cc >= CC_LAST);
    assign capture     = rise && !strike;
    assign abort       = expire && !strike;
    assign cc_inc      = cc + 32'd1;
    assign unused_lsbs = ^grid_u_center[DATA_W-17:0];

    // Next-state selection; a strike overrides whatever the sequencer was doing
    always_comb begin
        state_next = state;
        case (state)
            S_STRIKE: state_next = (rst_cnt == RST_LAST) ? S_IDLE : S_STRIKE;
            S_IDLE:   state_next = go ? S_LAUNCH : S_IDLE;
            S_LAUNCH: state_next = S_WAIT;
            default:  state_next = (rise || expire) ? S_IDLE : S_WAIT;
        endcase
        if (strike)
            state_next = S_STRIKE;
    end

    // State register; chip reset parks the grid in its reset window
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset)
            state <= S_STRIKE;
        else
            state <= state_next;
    end

    // Grid reset window length; a strike restarts the window
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset)
            rst_cnt <= '0;
        else if (strike)
            rst_cnt <= '0;
        else if (state == S_STRIKE)
            rst_cnt <= rst_cnt + 16'd1;
    end

    // Strike parameters held steady for the grid until the next strike
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            grid_u_init   <= '0;
            grid_rho_init <= '0;
            grid_height   <= '0;
        end else if (strike) begin
            grid_u_init   <= u_init_in;
            grid_rho_init <= rho_init_in;
            grid_height   <= height_in;
        end
    end

    // Step duration counter and done edge tracker, primed at launch so a stale done level is not a completion
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            cc     <= '0;
            done_d <= 1'b0;
        end else if (state == S_LAUNCH) begin
            cc     <= '0;
            done_d <= grid_done;
        end else if (state == S_WAIT) begin
            cc     <= cc_inc;
            done_d <= grid_done;
        end
    end

    // Output sample register with valid/ready handshake
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else if (state == S_STRIKE) begin
            sample_valid <= 1'b0;
        end else if (capture) begin
            sample_valid <= 1'b1;
            sample_data  <= grid_u_center[DATA_W-1:DATA_W-16];
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Debug counters: completed steps and duration of the last step
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            step_count  <= '0;
            step_cycles <= '0;
        end else if (state == S_STRIKE) begin
            step_count  <= '0;
            step_cycles <= '0;
        end else if (capture) begin
            step_count  <= step_count + 1'b1;
            step_cycles <= (|cc_inc[31:16]) ? 16'hFFFF : cc_inc[15:0];
        end
    end

    // Sticky timeout flag, cleared only by a strike window
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset)
            timeout_err <= 1'b0;
        else if (state == S_STRIKE)
            timeout_err <= 1'b0;
        else if (abort)
            timeout_err <= 1'b1;
    end
endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb_drum_step_sequencer: directed scenarios plus randomized grid/audio traffic against a transaction-level model
module tb_drum_step_sequencer;
    logic        clk_50;
    logic        reset;
    logic        run_en;
    logic        strike;
    logic [17:0] u_init_in;
    logic [17:0] rho_init_in;
    logic [8:0]  height_in;
    logic        grid_reset;
    logic        grid_start;
    logic [17:0] grid_u_init;
    logic [17:0] grid_rho_init;
    logic [8:0]  grid_height;
    logic        grid_done;
    logic [17:0] grid_u_center;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] step_count;
    logic [15:0] step_cycles;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    drum_step_sequencer dut (
        .clk_50        (clk_50),
        .reset         (reset),
        .run_en        (run_en),
        .strike        (strike),
        .u_init_in     (u_init_in),
        .rho_init_in   (rho_init_in),
        .height_in     (height_in),
        .grid_reset    (grid_reset),
        .grid_start    (grid_start),
        .grid_u_init   (grid_u_init),
        .grid_rho_init (grid_rho_init),
        .grid_height   (grid_height),
        .grid_done     (grid_done),
        .grid_u_center (grid_u_center),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .step_count    (step_count),
        .step_cycles   (step_cycles),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Count clock cycles until grid_reset drops; the window must last 4 cycles
    task automatic wait_reset_window(input string tag);
        int n = 0;
        do begin
            @(negedge clk_50);
            n++;
        end while (grid_reset && n < 20);
        check(tag, n, 4);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            @(negedge clk_50);
            n++;
        end while (!grid_start && n < 20);
        check(tag, n, 1);
    endtask

    task automatic do_strike(input logic [17:0] u, input logic [17:0] r, input logic [8:0] h);
        u_init_in   = u;
        rho_init_in = r;
        height_in   = h;
        strike      = 1'b1;
        @(negedge clk_50);
        strike      = 1'b0;
        u_init_in   = ~u;
        rho_init_in = ~r;
        height_in   = ~h;
        check("strike_u", grid_u_init, u);
        check("strike_rho", grid_rho_init, r);
        check("strike_h", grid_height, h);
        check("strike_greset", grid_reset, 1);
        wait_reset_window("strike_window");
    endtask

    // Called at the launch cycle: grid reports done d cycles after grid_start with amplitude uc
    task automatic run_step(input int d, input logic [17:0] uc, input int exp_cnt);
        @(negedge clk_50);
        check("start_width", grid_start, 0);
        repeat (d - 1) @(negedge clk_50);
        check("pre_valid", sample_valid, 0);
        grid_done     = 1'b1;
        grid_u_center = uc;
        @(negedge clk_50);
        check("cap_valid", sample_valid, 1);
        check("cap_data", sample_data, uc[17:2]);
        check("cap_cycles", step_cycles, d);
        check("cap_count", step_count, exp_cnt);
        grid_done = 1'b0;
    endtask

    initial begin
        int n;
        int starts;
        int cyc;
        int done_steps;
        int k;
        int d;
        int h;
        bit in_step;
        bit pend;
        bit rdy;
        bit ren;
        logic [17:0] uc;
        logic [15:0] q[$];
        int exp_count;

        reset = 1'b0; run_en = 1'b0; strike = 1'b0;
        u_init_in = '0; rho_init_in = '0; height_in = '0;
        grid_done = 1'b0; grid_u_center = '0; sample_ready = 1'b0;

        repeat (3) @(negedge clk_50);
        check("rst_greset", grid_reset, 1);
        check("rst_busy", busy, 1);
        check("rst_start", grid_start, 0);
        reset = 1'b1;
        wait_reset_window("rst_window");
        check("idle_busy", busy, 0);
        check("idle_count", step_count, 0);
        check("idle_cycles", step_cycles, 0);
        check("idle_valid", sample_valid, 0);
        check("idle_terr", timeout_err, 0);
        check("idle_uinit", grid_u_init, 0);

        do_strike(18'h08000, 18'h04000, 9'd29);
        run_en = 1'b1;
        wait_start("n_start");
        run_step(100, 18'h1FFFC, 1);
        check("n_data_lit", sample_data, 16'h7FFF);

        starts = 0;
        repeat (50) begin
            @(negedge clk_50);
            starts += int'(grid_start);
        end
        check("bp_starts", starts, 0);
        check("bp_hold", sample_data, 16'h7FFF);
        check("bp_valid", sample_valid, 1);
        sample_ready = 1'b1;
        wait_start("bp_start");
        check("bp_accept", sample_valid, 0);
        sample_ready = 1'b0;

        repeat (20) @(negedge clk_50);
        check("mid_busy", busy, 1);
        check("mid_count_before", step_count, 1);
        grid_done     = 1'b1;
        grid_u_center = 18'h15555;
        run_en        = 1'b0;
        do_strike(18'h3F000, 18'h01234, 9'd100);
        grid_done = 1'b0;
        check("mid_valid", sample_valid, 0);
        check("mid_count", step_count, 0);
        check("mid_busy_after", busy, 0);

        run_en = 1'b1;
        wait_start("to_start");
        run_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk_50);
            n++;
        end while (busy && n < 5000);
        check("to_cycles", n, 4097);
        check("to_err", timeout_err, 1);
        check("to_valid", sample_valid, 0);
        check("to_count", step_count, 0);

        u_init_in = 18'h00111;
        strike    = 1'b1;
        @(negedge clk_50);
        strike = 1'b0;
        repeat (2) @(negedge clk_50);
        do_strike(18'h2ABCD, 18'h13579, 9'd511);
        check("to_cleared", timeout_err, 0);

        cyc = 0; done_steps = 0; k = 0; d = 0; h = 0;
        in_step = 1'b0; pend = 1'b0; exp_count = 0; uc = '0;
        while (cyc < 70000) begin
            @(negedge clk_50);
            cyc++;
            check("launch", grid_start, pend);
            if (grid_start) begin
                check("overlap", in_step, 0);
                in_step = 1'b1;
                k = 0;
                d = $urandom_range(40, 2);
                h = $urandom_range(d - 2, 0);
                uc = 18'($urandom);
            end else if (in_step) begin
                k++;
                if (k == d + 1) begin
                    check("r_valid", sample_valid, 1);
                    check("r_cycles", step_cycles, d);
                    check("r_count", step_count, exp_count);
                    check("r_idle", busy, 0);
                    check("r_greset", grid_reset, 0);
                    in_step = 1'b0;
                    done_steps++;
                end
            end
            if (done_steps >= 1000 && !busy && !sample_valid)
                break;
            if (in_step && k > h && k < d) begin
                grid_done     = 1'b0;
                grid_u_center = 18'($urandom);
            end else if (in_step && k == d) begin
                grid_done     = 1'b1;
                grid_u_center = uc;
                q.push_back(uc[17:2]);
                exp_count++;
            end else if (!in_step && $urandom_range(3, 0) == 0) begin
                grid_done = 1'b0;
            end
            rdy = ($urandom_range(3, 0) != 0);
            ren = (done_steps < 1000) && ($urandom_range(15, 0) != 0);
            if (sample_valid && rdy) begin
                check("q_depth", q.size() > 0, 1);
                if (q.size() > 0)
                    check("r_sample", sample_data, q.pop_front());
            end
            sample_ready = rdy;
            run_en       = ren;
            pend         = !busy && ren && (!sample_valid || rdy);
        end
        check("budget", cyc < 70000, 1);
        check("final_count", step_count, 1000);
        check("final_q", q.size(), 0);
        check("final_err", timeout_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
